// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: two-way round-robin owner of the 8-bit LFSR stream-cipher core.
// Grants the core to one requester per packet, loads its key/tap, paces its
// bytes into the core, routes the ciphered bytes back, waits for all results
// (or a timeout), then stops the core and hands it to the other channel.
module lfsr_arbiter #(
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [7:0] key0,
    input  logic [7:0] key1,
    input  logic [2:0] tap0,
    input  logic [2:0] tap1,
    input  logic [7:0] len0,
    input  logic [7:0] len1,
    input  logic [1:0] in_valid,
    input  logic [7:0] in_byte0,
    input  logic [7:0] in_byte1,
    output logic [1:0] in_ready,
    output logic [7:0] out_byte,
    output logic [1:0] out_valid,
    output logic [1:0] done,
    output logic       err,
    output logic [1:0] grant,
    output logic       busy,
    output logic [7:0] core_key,
    output logic [2:0] core_tap,
    output logic       core_start,
    output logic       core_stop,
    output logic [7:0] core_in_byte,
    output logic       core_in_en,
    input  logic [7:0] core_out_byte,
    input  logic       core_out_en
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_STREAM,
        S_DRAIN,
        S_STOP
    } state_e;

    // Settle counter holds 0..SETTLE_CYCLES-1; idle counter holds 0..TIMEOUT-1.
    localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e          state_q,        state_d;
    logic [1:0]      grant_q,        grant_d;
    logic            last_q,         last_d;          // index of last served channel
    logic [8:0]      remaining_q,    remaining_d;     // bytes still to accept
    logic [8:0]      outstanding_q,  outstanding_d;   // bytes sent, result pending
    logic [SW-1:0]   settle_q,       settle_d;
    logic [TW-1:0]   idle_q,         idle_d;          // consecutive silent DRAIN cycles
    logic            timed_out_q,    timed_out_d;
    logic [7:0]      core_key_q,     core_key_d;
    logic [2:0]      core_tap_q,     core_tap_d;
    logic            core_start_q,   core_start_d;
    logic            core_stop_q,    core_stop_d;
    logic [7:0]      core_in_byte_q, core_in_byte_d;
    logic            core_in_en_q,   core_in_en_d;
    logic [1:0]      in_ready_q,     in_ready_d;
    logic [1:0]      done_q,         done_d;
    logic            err_q,          err_d;
    logic            busy_q,         busy_d;

    // ------------------------------------------------------------------
    // Per-cycle events
    // ------------------------------------------------------------------
    logic       hs;        // source byte accepted this cycle
    logic       ret;       // core result returned to the owning channel
    logic       pick;      // channel chosen in IDLE
    logic [7:0] src_byte;  // byte offered by the granted channel

    // Decode handshake, result return and the round-robin choice.
    always_comb begin
        hs       = |(in_ready_q & in_valid);
        ret      = core_out_en & (|grant_q);
        pick     = (req == 2'b11) ? ~last_q : req[1];
        src_byte = grant_q[1] ? in_byte1 : in_byte0;
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        // NOTE: every _d gets a default here so no path through the case infers a latch.
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        remaining_d    = remaining_q;
        outstanding_d  = outstanding_q;
        settle_d       = settle_q;
        idle_d         = idle_q;
        timed_out_d    = timed_out_q;
        core_key_d     = core_key_q;
        core_tap_d     = core_tap_q;
        core_start_d   = 1'b0;
        core_stop_d    = 1'b0;
        core_in_en_d   = hs;
        core_in_byte_d = hs ? src_byte : core_in_byte_q;
        done_d         = 2'b00;
        err_d          = 1'b0;

        // Outstanding tracks sent-minus-returned; simultaneous events cancel,
        // and a return with nothing outstanding is dropped.
        case ({hs, ret})
            2'b10:   outstanding_d = outstanding_q + 9'd1;
            2'b01:   outstanding_d = (outstanding_q != 9'd0) ? outstanding_q - 9'd1
                                                             : outstanding_q;
            default: outstanding_d = outstanding_q;
        endcase

        case (state_q)
            S_IDLE: begin
                outstanding_d = 9'd0;
                if (|req) begin
                    grant_d      = pick ? 2'b10 : 2'b01;
                    core_key_d   = pick ? key1 : key0;
                    core_tap_d   = pick ? tap1 : tap0;
                    remaining_d  = pick ? ((len1 == 8'd0) ? 9'd256 : {1'b0, len1})
                                        : ((len0 == 8'd0) ? 9'd256 : {1'b0, len0});
                    timed_out_d  = 1'b0;
                    core_start_d = 1'b1;
                    state_d      = S_LOAD;
                end
            end

            S_LOAD: begin
                if (SETTLE_CYCLES == 0) begin
                    state_d = S_STREAM;
                end else begin
                    settle_d = SW'(SETTLE_CYCLES - 1);
                    state_d  = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_STREAM;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end

            S_STREAM: begin
                remaining_d = remaining_q - {8'd0, hs};
                if (remaining_d == 9'd0) begin
                    idle_d  = '0;
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (outstanding_q == 9'd0) begin
                    state_d = S_STOP;
                end else if (ret) begin
                    idle_d = '0;
                end else if (idle_q == TW'(TIMEOUT - 1)) begin
                    timed_out_d = 1'b1;
                    state_d     = S_STOP;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
                if (state_d == S_STOP) begin
                    core_stop_d = 1'b1;
                    done_d      = grant_q;
                    err_d       = timed_out_d;
                end
            end

            S_STOP: begin
                last_d  = grant_q[1];
                grant_d = 2'b00;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Ready is registered, so it already reflects the decrement above and
        // never admits a byte beyond the packet length.
        in_ready_d = ((state_d == S_STREAM) && (remaining_d != 9'd0)) ? grant_d : 2'b00;
        busy_d     = (state_d != S_IDLE);
    end

    // Register all state and outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            grant_q        <= 2'b00;
            last_q         <= 1'b1;
            remaining_q    <= 9'd0;
            outstanding_q  <= 9'd0;
            settle_q       <= '0;
            idle_q         <= '0;
            timed_out_q    <= 1'b0;
            core_key_q     <= 8'd0;
            core_tap_q     <= 3'd0;
            core_start_q   <= 1'b0;
            core_stop_q    <= 1'b0;
            core_in_byte_q <= 8'd0;
            core_in_en_q   <= 1'b0;
            in_ready_q     <= 2'b00;
            done_q         <= 2'b00;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_q         <= last_d;
            remaining_q    <= remaining_d;
            outstanding_q  <= outstanding_d;
            settle_q       <= settle_d;
            idle_q         <= idle_d;
            timed_out_q    <= timed_out_d;
            core_key_q     <= core_key_d;
            core_tap_q     <= core_tap_d;
            core_start_q   <= core_start_d;
            core_stop_q    <= core_stop_d;
            core_in_byte_q <= core_in_byte_d;
            core_in_en_q   <= core_in_en_d;
            in_ready_q     <= in_ready_d;
            done_q         <= done_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready     = in_ready_q;
    assign out_byte     = core_out_byte;
    assign out_valid    = {2{core_out_en}} & grant_q;
    assign done         = done_q;
    assign err          = err_q;
    assign grant        = grant_q;
    assign busy         = busy_q;
    assign core_key     = core_key_q;
    assign core_tap     = core_tap_q;
    assign core_start   = core_start_q;
    assign core_stop    = core_stop_q;
    assign core_in_byte = core_in_byte_q;
    assign core_in_en   = core_in_en_q;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// tb_lfsr_arbiter: directed bench for lfsr_arbiter with a small LFSR core model.
module tb_lfsr_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] key0 = 8'd0, key1 = 8'd0;
    logic [2:0] tap0 = 3'd0, tap1 = 3'd0;
    logic [7:0] len0 = 8'd0, len1 = 8'd0;
    logic [1:0] in_valid = 2'b00;
    logic [7:0] in_byte0 = 8'd0, in_byte1 = 8'd0;
    logic [1:0] in_ready;
    logic [7:0] out_byte;
    logic [1:0] out_valid, done, grant;
    logic       err, busy;
    logic [7:0] core_key;
    logic [2:0] core_tap;
    logic       core_start, core_stop, core_in_en;
    logic [7:0] core_in_byte;
    logic [7:0] core_out_byte = 8'd0;
    logic       core_out_en = 1'b0;

    lfsr_arbiter dut (
        .clk(clk), .reset(reset), .req(req),
        .key0(key0), .key1(key1), .tap0(tap0), .tap1(tap1),
        .len0(len0), .len1(len1),
        .in_valid(in_valid), .in_byte0(in_byte0), .in_byte1(in_byte1),
        .in_ready(in_ready), .out_byte(out_byte), .out_valid(out_valid),
        .done(done), .err(err), .grant(grant), .busy(busy),
        .core_key(core_key), .core_tap(core_tap),
        .core_start(core_start), .core_stop(core_stop),
        .core_in_byte(core_in_byte), .core_in_en(core_in_en),
        .core_out_byte(core_out_byte), .core_out_en(core_out_en)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- core model: byte ^ lfsr, one-cycle latency ----------------
    logic       spur = 1'b0;     // inject a return strobe unrelated to any byte
    int         ans_limit = 1000;
    logic [7:0] m_s = 8'd0;
    logic [2:0] m_tp = 3'd0;
    int         m_ans = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_s           <= 8'd0;
            m_tp          <= 3'd0;
            m_ans         <= 0;
            core_out_en   <= 1'b0;
            core_out_byte <= 8'd0;
        end else begin
            core_out_en <= spur | (core_in_en && (m_ans < ans_limit));
            if (core_start) begin
                m_s   <= core_key;
                m_tp  <= core_tap;
                m_ans <= 0;
            end else if (core_in_en) begin
                core_out_byte <= core_in_byte ^ m_s;
                m_s           <= {m_s[6:0], m_s[7] ^ m_s[m_tp]};
                if (m_ans < ans_limit) m_ans <= m_ans + 1;
            end
        end
    end

    // ---------------- protocol monitor ----------------
    logic       mon_clr = 1'b0;
    int         hs_cnt[2], ov_cnt[2], done_cnt[2];
    int         en_cnt, ready_viol, en_bad;
    logic       prev_hs;
    logic [7:0] prev_b;
    logic [1:0] glog[$];

    always @(posedge clk) begin
        if (mon_clr) begin
            for (int c = 0; c < 2; c++) begin
                hs_cnt[c]   <= 0;
                ov_cnt[c]   <= 0;
                done_cnt[c] <= 0;
            end
            en_cnt     <= 0;
            ready_viol <= 0;
            en_bad     <= 0;
            glog.delete();
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (in_valid[c] && in_ready[c]) hs_cnt[c] <= hs_cnt[c] + 1;
                if (out_valid[c]) ov_cnt[c] <= ov_cnt[c] + 1;
                if (done[c]) done_cnt[c] <= done_cnt[c] + 1;
            end
            if (core_in_en) en_cnt <= en_cnt + 1;
            if ((in_ready & ~grant) != 2'b00) ready_viol <= ready_viol + 1;
            if (core_in_en !== prev_hs) en_bad <= en_bad + 1;
            else if (core_in_en && (core_in_byte !== prev_b)) en_bad <= en_bad + 1;
            if (core_start) glog.push_back(grant);
        end
        if (!reset) prev_hs <= 1'b0;
        else        prev_hs <= |(in_valid & in_ready);
        prev_b <= in_ready[1] ? in_byte1 : in_byte0;
    end

    // ---------------- source driver, advanced once per cycle ----------------
    logic       src_auto = 1'b0;
    logic [1:0] src_on = 2'b00;
    logic [5:0] pat[2];
    int         idx[2], bcnt[2];

    task automatic step();
        logic [1:0] hs, rs;
        hs = in_valid & in_ready;
        rs = in_ready;
        @(posedge clk);
        #1;
        if (src_auto) begin
            for (int c = 0; c < 2; c++) begin
                if (hs[c]) bcnt[c]++;
                if (rs[c]) idx[c]++;
                in_valid[c] = src_on[c] & ((idx[c] < 6) ? pat[c][idx[c][2:0]] : 1'b1);
            end
            in_byte0 = 8'(bcnt[0]);
            in_byte1 = 8'(bcnt[1]);
        end
    endtask

    task automatic src_setup(input int c, input logic on, input logic [5:0] p);
        src_auto  = 1'b1;
        src_on[c] = on;
        pat[c]    = p;
        idx[c]    = 0;
        bcnt[c]   = 0;
        in_valid[c] = on & p[0];
        in_byte0 = 8'(bcnt[0]);
        in_byte1 = 8'(bcnt[1]);
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    task automatic wait_done(input int c, input int budget, output logic e);
        logic seen;
        seen = 1'b0;
        e    = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            step();
            if (done[c]) begin
                seen = 1'b1;
                e    = err;
            end
        end
        check($sformatf("done%0d within budget", c), {31'd0, seen}, 32'd1);
    endtask

    function automatic logic [12:0] ctrl_vec();
        return {grant, in_ready, core_start, core_stop, core_in_en, out_valid, done, err, busy};
    endfunction

    function automatic logic [12:0] mk(input logic [1:0] g, input logic [1:0] r,
                                       input logic st, input logic sp, input logic en,
                                       input logic [1:0] ov, input logic [1:0] dn,
                                       input logic er, input logic bz);
        return {g, r, st, sp, en, ov, dn, er, bz};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        check("reset ctrl", {19'd0, ctrl_vec()}, 32'd0);
        check("reset key/tap", {21'd0, core_key, core_tap}, 32'd0);
        reset = 1'b1;
        step();
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  vld;
        logic [7:0]  b0;
        logic [12:0] exp;
        logic [7:0]  exp_cib;
        logic [7:0]  exp_ob;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        int   n;
        logic ok;

        // Single packet on channel 0, cycle by cycle; cipher values for key A5,
        // tap 3: A5, 4A, 95, 2C for bytes 00..03.
        tbl[0]  = '{2'b01, 2'b01, 8'h00, mk(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0), 8'h00, 8'h00};
        tbl[1]  = '{2'b00, 2'b01, 8'h00, mk(2'b01, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 1), 8'h00, 8'h00};
        tbl[2]  = '{2'b00, 2'b01, 8'h00, mk(2'b01, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1), 8'h00, 8'h00};
        tbl[3]  = '{2'b00, 2'b01, 8'h00, mk(2'b01, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1), 8'h00, 8'h00};
        tbl[4]  = '{2'b00, 2'b01, 8'h00, mk(2'b01, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 1), 8'h00, 8'h00};
        tbl[5]  = '{2'b00, 2'b01, 8'h01, mk(2'b01, 2'b01, 0, 0, 1, 2'b00, 2'b00, 0, 1), 8'h00, 8'h00};
        tbl[6]  = '{2'b00, 2'b01, 8'h02, mk(2'b01, 2'b01, 0, 0, 1, 2'b01, 2'b00, 0, 1), 8'h01, 8'hA5};
        tbl[7]  = '{2'b00, 2'b01, 8'h03, mk(2'b01, 2'b01, 0, 0, 1, 2'b01, 2'b00, 0, 1), 8'h02, 8'h4A};
        tbl[8]  = '{2'b00, 2'b01, 8'h04, mk(2'b01, 2'b00, 0, 0, 1, 2'b01, 2'b00, 0, 1), 8'h03, 8'h95};
        tbl[9]  = '{2'b00, 2'b01, 8'h04, mk(2'b01, 2'b00, 0, 0, 0, 2'b01, 2'b00, 0, 1), 8'h00, 8'h2C};
        tbl[10] = '{2'b00, 2'b01, 8'h04, mk(2'b01, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1), 8'h00, 8'h00};
        tbl[11] = '{2'b00, 2'b01, 8'h04, mk(2'b01, 2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 1), 8'h00, 8'h00};
        tbl[12] = '{2'b00, 2'b00, 8'h00, mk(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0), 8'h00, 8'h00};

        pat[0] = 6'b111111; pat[1] = 6'b111111;
        idx[0] = 0; idx[1] = 0; bcnt[0] = 0; bcnt[1] = 0;

        #1;
        do_reset();
        clear_mon();

        // ---- single packet, table driven ----
        key0 = 8'hA5; tap0 = 3'd3; len0 = 8'd4;
        for (int i = 0; i < 13; i++) begin
            req         = tbl[i].req;
            in_valid    = tbl[i].vld;
            in_byte0    = tbl[i].b0;
            check($sformatf("row%0d ctrl", i), {19'd0, ctrl_vec()}, {19'd0, tbl[i].exp});
            if (tbl[i].exp[6])
                check($sformatf("row%0d core_in_byte", i), {24'd0, core_in_byte}, {24'd0, tbl[i].exp_cib});
            if (tbl[i].exp[5:4] != 2'b00)
                check($sformatf("row%0d out_byte", i), {24'd0, out_byte}, {24'd0, tbl[i].exp_ob});
            step();
        end
        check("held core_key", {24'd0, core_key}, 32'hA5);
        check("held core_tap", {29'd0, core_tap}, 32'd3);

        // ---- a return strobe while idle never reaches out_valid ----
        spur = 1'b1;
        step();
        spur = 1'b0;
        check("idle strobe out_valid", {30'd0, out_valid}, 32'd0);
        step();

        // ---- contention: req=11 held for three packets, grants 0,1,0 ----
        do_reset();
        clear_mon();
        len0 = 8'd2; len1 = 8'd2; key1 = 8'h5A; tap1 = 3'd6;
        src_setup(0, 1'b1, 6'b111111);
        src_setup(1, 1'b1, 6'b111111);
        req = 2'b11;
        n = 0;
        for (int k = 0; k < 200 && n < 3; k++) begin
            step();
            if (|done) n++;
            if (n == 3) req = 2'b00;
        end
        req = 2'b00;
        step(); step();
        check("contention packets", n, 3);
        check("grant log size", glog.size(), 3);
        if (glog.size() == 3) begin
            check("grant #1", {30'd0, glog[0]}, 32'b01);
            check("grant #2", {30'd0, glog[1]}, 32'b10);
            check("grant #3", {30'd0, glog[2]}, 32'b01);
        end
        check("contention ready leak", ready_viol, 0);
        check("contention hs ch0", hs_cnt[0], 4);
        check("contention hs ch1", hs_cnt[1], 2);

        // ---- source stalls on channel 1 ----
        clear_mon();
        len1 = 8'd3;
        src_setup(0, 1'b0, 6'b111111);
        src_setup(1, 1'b1, 6'b101001);
        req = 2'b10;
        step();
        req = 2'b00;
        wait_done(1, 60, e);
        check("stall err", {31'd0, e}, 32'd0);
        step(); step();
        check("stall handshakes", hs_cnt[1], 3);
        check("stall core_in_en cycles", en_cnt, 3);
        check("stall in_en alignment", en_bad, 0);

        // ---- len 0 means 256 bytes ----
        clear_mon();
        len1 = 8'd0;
        src_setup(1, 1'b1, 6'b111111);
        req = 2'b10;
        step();
        req = 2'b00;
        wait_done(1, 400, e);
        check("len0 err", {31'd0, e}, 32'd0);
        step(); step();
        check("len0 handshakes", hs_cnt[1], 256);
        check("len0 results", ov_cnt[1], 256);
        check("len0 in_en alignment", en_bad, 0);

        // ---- core stops answering after 2 of 5: timeout ----
        clear_mon();
        len0 = 8'd5;
        ans_limit = 2;
        src_setup(1, 1'b0, 6'b111111);
        src_setup(0, 1'b1, 6'b111111);
        req = 2'b01;
        step();
        req = 2'b00;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (in_ready[0]) ok = 1'b1;
            else step();
        end
        check("timeout stream reached", {31'd0, ok}, 32'd1);
        for (int k = 0; k < 20 && in_ready[0]; k++) step();
        n = 0;
        while (!done[0] && n < 40) begin
            step();
            n++;
        end
        check("timeout done", {30'd0, done}, 32'b01);
        check("timeout drain cycles", n, 16);
        check("timeout err", {31'd0, err}, 32'd1);
        check("timeout core_stop", {31'd0, core_stop}, 32'd1);
        step(); step();
        check("timeout results", ov_cnt[0], 2);
        check("timeout handshakes", hs_cnt[0], 5);
        ans_limit = 1000;

        // ---- reset in the middle of a channel-1 stream ----
        clear_mon();
        key1 = 8'h3C; tap1 = 3'd5; len1 = 8'd8;
        src_setup(0, 1'b0, 6'b111111);
        src_setup(1, 1'b1, 6'b111111);
        req = 2'b10;
        step();
        req = 2'b00;
        for (int k = 0; k < 20 && !in_ready[1]; k++) step();
        step(); step();
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        step();
        check("mid reset ctrl", {19'd0, ctrl_vec()}, 32'd0);
        check("mid reset key/tap", {21'd0, core_key, core_tap}, 32'd0);
        check("mid reset core_in_byte", {24'd0, core_in_byte}, 32'd0);
        reset = 1'b1;
        step(); step(); step();
        check("no done after abort", done_cnt[1], 0);
        len0 = 8'd1;
        src_setup(0, 1'b1, 6'b111111);
        req = 2'b11;
        step();
        req = 2'b00;
        check("post-reset grant", {30'd0, grant}, 32'b01);
        check("post-reset core_start", {31'd0, core_start}, 32'd1);
        wait_done(0, 60, e);
        check("post-reset err", {31'd0, e}, 32'd0);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
